dcache_wt: RTL and testbench

DCACHE_WT -- requirements
Module: dcache_wt

---
 rtl/dcache_wt_if.sv | 26 ++
 rtl/dcache_wt.sv | 203 ++++++++++++++++++++
 tb/tb_dcache_wt.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_wt_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_if
//  Purpose  : Datapath-to-cache request/response bundle.
//  Revision : 1.0
// ============================================================================
interface cache_if;
    logic        read;
    logic [1:0]  write;
    logic [31:0] addr;
    logic [31:0] store;
    logic        done;
    logic        ready;
    logic [31:0] load;

    modport cache (
        input  read, write, addr, store, done,
        output ready, load
    );

    modport datapath (
        output read, write, addr, store, done,
        input  ready, load
    );
endinterface
`default_nettype wire

// File: rtl/dcache_wt.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_wt
//  Purpose  : Write-through, no-write-allocate data cache, one word per line,
//             1- or 2-way set associative with per-set LRU.
//  Revision : 1.0
// ============================================================================
module dcache_wt #(
    parameter int WAYS  = 1,
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic        clk,
    input  logic        rst,
    cache_if.cache      dp,
    input  logic        flush,
    output logic        mem_read,
    output logic [1:0]  mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_store,
    input  logic        mem_ready,
    input  logic [31:0] mem_load,
    output logic        hit
);

    localparam int c_tag_w = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [31:0]         r_addr;
    logic [31:0]         r_store;
    logic [1:0]          r_wr;
    logic [31:0]         r_load;
    logic                r_valid [WAYS][SETS];
    logic [c_tag_w-1:0]  r_tag   [WAYS][SETS];
    logic [31:0]         r_data  [WAYS][SETS];

    logic [IDX_W-1:0]    w_req_idx, w_lat_idx;
    logic [c_tag_w-1:0]  w_req_tag, w_lat_tag;
    logic [WAYS-1:0]     w_req_match, w_lat_match;
    logic                w_req_way, w_lat_way;
    logic                w_lookup_hit;
    logic [31:0]         w_req_data;
    logic                w_victim;
    logic                w_lru_cur;
    logic                w_fill_we, w_merge_we;
    logic [31:0]         w_merged;
    logic                w_lru_clr, w_lru_we, w_lru_val;
    logic [IDX_W-1:0]    w_lru_idx;

    function automatic logic [31:0] f_merge(input logic [31:0] old,
                                            input logic [31:0] st,
                                            input logic [1:0]  wr,
                                            input logic [1:0]  off);
        logic [31:0] m;
        m = old;
        case (wr)
            2'd1:    m[{off, 3'b000} +: 8]        = st[7:0];
            2'd2:    m[{off[1], 4'b0000} +: 16]   = st[15:0];
            2'd3:    m = st;
            default: m = old;
        endcase
        return m;
    endfunction

    assign w_req_idx = dp.addr[IDX_W+1:2];
    assign w_req_tag = dp.addr[31:IDX_W+2];
    assign w_lat_idx = r_addr[IDX_W+1:2];
    assign w_lat_tag = r_addr[31:IDX_W+2];

    // Two lookups: live request address (read hits) and latched address (fill/merge).
    always_comb begin
        w_req_way = 1'b0;
        w_lat_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            w_req_match[w] = r_valid[w][w_req_idx] && (r_tag[w][w_req_idx] == w_req_tag);
            w_lat_match[w] = r_valid[w][w_lat_idx] && (r_tag[w][w_lat_idx] == w_lat_tag);
            if (w_req_match[w]) w_req_way = 1'(w);
            if (w_lat_match[w]) w_lat_way = 1'(w);
        end
    end

    assign w_req_data   = r_data[w_req_way][w_req_idx];
    assign w_lookup_hit = (r_state == IDLE) && dp.read && (dp.write == 2'b00)
                          && !flush && (|w_req_match);

    assign hit      = w_lookup_hit;
    assign dp.ready = w_lookup_hit || (r_state == RESP);
    assign dp.load  = w_lookup_hit ? w_req_data : r_load;

    always_comb begin
        if (!r_valid[0][w_lat_idx])
            w_victim = 1'b0;
        else if ((WAYS == 2) && !r_valid[WAYS-1][w_lat_idx])
            w_victim = 1'b1;
        else
            w_victim = w_lru_cur;
    end

    assign w_fill_we  = (r_state == FILL)  && mem_ready && !rst;
    assign w_merge_we = (r_state == WRITE) && mem_ready && !rst && (|w_lat_match);
    assign w_merged   = f_merge(r_data[w_lat_way][w_lat_idx], r_store, r_wr, r_addr[1:0]);

    assign w_lru_clr = (r_state == IDLE) && flush;
    assign w_lru_we  = w_lookup_hit || w_fill_we;
    assign w_lru_idx = w_fill_we ? w_lat_idx : w_req_idx;
    assign w_lru_val = w_fill_we ? ~w_victim : ~w_req_way;

    generate
        if (WAYS == 2) begin : g_lru
            logic r_lru [SETS];
            always_ff @(posedge clk) begin
                if (rst || w_lru_clr) begin
                    for (int s = 0; s < SETS; s++) r_lru[s] <= 1'b0;
                end else if (w_lru_we) begin
                    r_lru[w_lru_idx] <= w_lru_val;
                end
            end
            assign w_lru_cur = r_lru[w_lat_idx];
        end else begin : g_no_lru
            logic w_unused_lru;
            assign w_unused_lru = &{1'b0, w_lru_clr, w_lru_we, w_lru_val, w_lru_idx};
            assign w_lru_cur    = 1'b0;
        end
    endgenerate

    // Tag/data storage carries no reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[w_victim][w_lat_idx] <= mem_load;
            r_tag[w_victim][w_lat_idx]  <= w_lat_tag;
        end else if (w_merge_we) begin
            r_data[w_lat_way][w_lat_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= 32'd0;
            r_store   <= 32'd0;
            r_wr      <= 2'd0;
            r_load    <= 32'd0;
            mem_read  <= 1'b0;
            mem_write <= 2'd0;
            mem_addr  <= 32'd0;
            mem_store <= 32'd0;
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    r_valid[w][s] <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        for (int w = 0; w < WAYS; w++)
                            for (int s = 0; s < SETS; s++)
                                r_valid[w][s] <= 1'b0;
                    end
                    if (dp.write != 2'b00) begin
                        r_addr    <= dp.addr;
                        r_store   <= dp.store;
                        r_wr      <= dp.write;
                        mem_write <= dp.write;
                        mem_addr  <= dp.addr;
                        mem_store <= dp.store;
                        r_state   <= WRITE;
                    end else if (dp.read && !w_lookup_hit) begin
                        r_addr   <= dp.addr;
                        mem_read <= 1'b1;
                        mem_addr <= {dp.addr[31:2], 2'b00};
                        r_state  <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        r_valid[w_victim][w_lat_idx] <= 1'b1;
                        r_load   <= mem_load;
                        mem_read <= 1'b0;
                        r_state  <= RESP;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_write <= 2'd0;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    if (dp.done) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_wt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_wt
//  Purpose  : Directed self-checking bench for dcache_wt (2-way, 4 sets).
//  Revision : 1.0
// ============================================================================
module tb_dcache_wt;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_store;
    logic        mem_ready;
    logic [31:0] mem_load;
    logic        hit;
    int          checks   = 0;
    int          failures = 0;

    cache_if dpi();

    dcache_wt #(.WAYS(2), .SETS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .dp        (dpi),
        .flush     (flush),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_store (mem_store),
        .mem_ready (mem_ready),
        .mem_load  (mem_load),
        .hit       (hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read; on a miss the memory answers with val on the third FILL cycle.
    task automatic rd(input logic [31:0] a, input logic exp_hit, input logic [31:0] val,
                      input logic fl, input string tag);
        @(negedge clk);
        dpi.read = 1'b1; dpi.write = 2'd0; dpi.addr = a; flush = fl;
        #1;
        chk({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        if (exp_hit) begin
            chk({tag, "_ready"}, 32'(dpi.ready), 32'd1);
            chk({tag, "_load"}, dpi.load, val);
            chk({tag, "_nomemrd"}, 32'(mem_read), 32'd0);
            @(posedge clk); #1;
            dpi.read = 1'b0;
        end else begin
            chk({tag, "_ready0"}, 32'(dpi.ready), 32'd0);
            @(posedge clk); #1;
            dpi.read = 1'b0; dpi.addr = 32'hFFFF_FFFC; flush = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk({tag, "_memrd"}, 32'(mem_read), 32'd1);
                chk({tag, "_memwr"}, 32'(mem_write), 32'd0);
                chk({tag, "_memaddr"}, mem_addr, {a[31:2], 2'b00});
                chk({tag, "_fillrdy"}, 32'(dpi.ready), 32'd0);
                if (i == 2) begin mem_ready = 1'b1; mem_load = val; end
            end
            @(posedge clk); #1;
            mem_ready = 1'b0; mem_load = 32'h0BAD_0BAD;
            @(negedge clk);
            chk({tag, "_respready"}, 32'(dpi.ready), 32'd1);
            chk({tag, "_respload"}, dpi.load, val);
            chk({tag, "_respmemrd"}, 32'(mem_read), 32'd0);
            dpi.done = 1'b1;
            @(posedge clk); #1;
            dpi.done = 1'b0;
        end
    endtask

    // Write-through; read is held high too so write priority is exercised.
    task automatic wr(input logic [31:0] a, input logic [1:0] w, input logic [31:0] st,
                      input string tag);
        @(negedge clk);
        dpi.write = w; dpi.read = 1'b1; dpi.addr = a; dpi.store = st;
        #1;
        chk({tag, "_ready0"}, 32'(dpi.ready), 32'd0);
        chk({tag, "_hit0"}, 32'(hit), 32'd0);
        @(posedge clk); #1;
        dpi.write = 2'd0; dpi.read = 1'b0; dpi.addr = 32'd0; dpi.store = 32'd0;
        @(negedge clk);
        chk({tag, "_memwr"}, 32'(mem_write), 32'(w));
        chk({tag, "_memrd"}, 32'(mem_read), 32'd0);
        chk({tag, "_memaddr"}, mem_addr, a);
        chk({tag, "_memstore"}, mem_store, st);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_respready"}, 32'(dpi.ready), 32'd1);
        chk({tag, "_respmemwr"}, 32'(mem_write), 32'd0);
        dpi.done = 1'b1;
        @(posedge clk); #1;
        dpi.done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_ready = 1'b0; mem_load = 32'd0;
        dpi.read = 1'b0; dpi.write = 2'd0; dpi.addr = 32'd0; dpi.store = 32'd0; dpi.done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(dpi.ready), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_memrd", 32'(mem_read), 32'd0);
        chk("rst_memwr", 32'(mem_write), 32'd0);
        chk("rst_memaddr", mem_addr, 32'd0);
        chk("rst_memstore", mem_store, 32'd0);
        chk("rst_load", dpi.load, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LRU replacement in set 0
        rd(32'h000, 1'b0, 32'h0000_00A0, 1'b0, "lru_f0");
        rd(32'h010, 1'b0, 32'h0000_00A1, 1'b0, "lru_f1");
        rd(32'h000, 1'b1, 32'h0000_00A0, 1'b0, "lru_h0");
        rd(32'h020, 1'b0, 32'h0000_00A2, 1'b0, "lru_f2");
        rd(32'h000, 1'b1, 32'h0000_00A0, 1'b0, "lru_h0b");
        rd(32'h020, 1'b1, 32'h0000_00A2, 1'b0, "lru_h2");
        rd(32'h010, 1'b0, 32'h0000_00A1, 1'b0, "lru_m1");
        rd(32'h020, 1'b1, 32'h0000_00A2, 1'b0, "lru_h2b");
        rd(32'h000, 1'b0, 32'h0000_00A0, 1'b0, "lru_m0");

        // Standalone flush
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        rd(32'h020, 1'b0, 32'h0000_00A2, 1'b0, "flush_m2");

        // Cold read, hit, and byte/halfword/word merges
        rd(32'h100, 1'b0, 32'hDEAD_BEEF, 1'b0, "cold");
        rd(32'h100, 1'b1, 32'hDEAD_BEEF, 1'b0, "warm");
        wr(32'h102, 2'd1, 32'h0000_00AA, "wb2");
        rd(32'h100, 1'b1, 32'hDEAA_BEEF, 1'b0, "rb2");
        wr(32'h102, 2'd2, 32'h0000_5566, "wh1");
        rd(32'h100, 1'b1, 32'h5566_BEEF, 1'b0, "rh1");
        wr(32'h101, 2'd1, 32'h0000_0077, "wb1");
        rd(32'h100, 1'b1, 32'h5566_77EF, 1'b0, "rb1");
        wr(32'h100, 2'd3, 32'hCAFE_F00D, "ww");
        rd(32'h100, 1'b1, 32'hCAFE_F00D, 1'b0, "rw");
        rd(32'h020, 1'b1, 32'h0000_00A2, 1'b0, "other_way");

        // Write miss does not allocate
        wr(32'h200, 2'd3, 32'h1111_1111, "wmiss");
        rd(32'h200, 1'b0, 32'h2222_2222, 1'b0, "rmiss");
        rd(32'h200, 1'b1, 32'h2222_2222, 1'b0, "rmiss_hit");

        // Flush with a same-cycle read of a cached line
        rd(32'h200, 1'b0, 32'h3333_3333, 1'b1, "flush_rd");
        rd(32'h100, 1'b0, 32'hDEAD_BEEF, 1'b0, "post_flush");

        // Reset in the middle of a fill
        @(negedge clk);
        dpi.read = 1'b1; dpi.addr = 32'h300;
        @(posedge clk); #1;
        dpi.read = 1'b0;
        @(negedge clk);
        chk("midfill_memrd", 32'(mem_read), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_memrd", 32'(mem_read), 32'd0);
        chk("postrst_ready", 32'(dpi.ready), 32'd0);
        rd(32'h300, 1'b0, 32'h4444_4444, 1'b0, "rst_refill");
        rd(32'h100, 1'b0, 32'hDEAD_BEEF, 1'b0, "rst_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
